// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Shares one toggle-handshake SDRAM port between the Oric CPU RAM
//            bus (strict priority, coalescing) and a one-entry loader buffer.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  input  logic [15:0] cpu_ad,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  output logic        cpu_busy,
  input  logic        ldr_wr,
  input  logic [15:0] ldr_ad,
  input  logic [7:0]  ldr_d,
  output logic        ldr_busy,
  output logic        ldr_ovf,
  output logic        timeout_err,
  output logic        sd_req,
  input  logic        sd_ack,
  output logic [15:0] sd_a,
  output logic        sd_we,
  output logic [1:0]  sd_ds,
  output logic [15:0] sd_d,
  input  logic [15:0] sd_q
);

  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_CPU = 2'd2,
    ST_WAIT_LDR = 2'd3
  } state_t;

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  state_t      w_next;

  logic        r_rd_q;
  logic        r_wr_q;
  logic [15:0] r_ad_q;
  logic        w_rd;
  logic        w_wr;
  logic        w_cpu_evt;

  logic        r_cpu_pend;
  logic        r_cpu_we;
  logic [15:0] r_cpu_a;
  logic [7:0]  r_cpu_d;

  logic        r_ldr_pend;
  logic [15:0] r_ldr_a;
  logic [7:0]  r_ldr_d;

  logic [7:0]  r_wait_cnt;

  logic        w_issue_cpu;
  logic        w_issue_ldr;
  logic        w_done;
  logic        w_tmo;

  assign w_rd = cpu_cs & cpu_oe;
  assign w_wr = cpu_cs & cpu_we;
  // A read whose address moves while oe stays asserted is a fresh access.
  assign w_cpu_evt = (w_rd & ~r_rd_q) | (w_wr & ~r_wr_q) | (w_rd & (cpu_ad != r_ad_q));

  assign cpu_busy = r_cpu_pend | (r_state == ST_WAIT_CPU);
  assign ldr_busy = r_ldr_pend | (r_state == ST_WAIT_LDR);

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= ST_SYNC;
    else       r_state <= w_next;
  end

  // Next-state and transfer decisions; completion beats timeout on the same edge.
  always_comb begin
    w_next      = r_state;
    w_issue_cpu = 1'b0;
    w_issue_ldr = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_SYNC: w_next = ST_IDLE;
      ST_IDLE: begin
        if (r_cpu_pend) begin
          w_issue_cpu = 1'b1;
          w_next      = ST_WAIT_CPU;
        end else if (r_ldr_pend) begin
          w_issue_ldr = 1'b1;
          w_next      = ST_WAIT_LDR;
        end
      end
      ST_WAIT_CPU, ST_WAIT_LDR: begin
        if (sd_ack == sd_req) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end else if (r_wait_cnt == C_TIMEOUT - 8'd1) begin
          w_tmo  = 1'b1;
          w_next = ST_SYNC;
        end
      end
      default: w_next = ST_SYNC;
    endcase
  end

  // Bus edge detection plus CPU and loader capture; a new capture beats an issue clear.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_rd_q     <= 1'b0;
      r_wr_q     <= 1'b0;
      r_ad_q     <= 16'h0000;
      r_cpu_pend <= 1'b0;
      r_cpu_we   <= 1'b0;
      r_cpu_a    <= 16'h0000;
      r_cpu_d    <= 8'h00;
      r_ldr_pend <= 1'b0;
      r_ldr_a    <= 16'h0000;
      r_ldr_d    <= 8'h00;
      ldr_ovf    <= 1'b0;
    end else begin
      r_rd_q <= w_rd;
      r_wr_q <= w_wr;
      r_ad_q <= cpu_ad;
      if (w_issue_cpu) r_cpu_pend <= 1'b0;
      if (w_cpu_evt) begin
        r_cpu_pend <= 1'b1;
        r_cpu_we   <= w_wr;
        r_cpu_a    <= cpu_ad;
        r_cpu_d    <= cpu_d;
      end
      if (w_issue_ldr) r_ldr_pend <= 1'b0;
      if (ldr_wr) begin
        if (!ldr_busy) begin
          r_ldr_pend <= 1'b1;
          r_ldr_a    <= ldr_ad;
          r_ldr_d    <= ldr_d;
        end else begin
          ldr_ovf <= 1'b1;
        end
      end
    end
  end

  // SDRAM request side, wait counter and CPU read-data return.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sd_req      <= 1'b0;
      sd_a        <= 16'h0000;
      sd_we       <= 1'b0;
      sd_ds       <= 2'b11;
      sd_d        <= 16'h0000;
      cpu_q       <= 8'h00;
      timeout_err <= 1'b0;
      r_wait_cnt  <= 8'h00;
    end else begin
      if (r_state == ST_SYNC) begin
        sd_req <= sd_ack;
      end
      if (w_issue_cpu) begin
        sd_req     <= ~sd_req;
        sd_a       <= r_cpu_a;
        sd_we      <= r_cpu_we;
        sd_ds      <= r_cpu_we ? (r_cpu_a[0] ? 2'b10 : 2'b01) : 2'b11;
        sd_d       <= {r_cpu_d, r_cpu_d};
        r_wait_cnt <= 8'h00;
      end else if (w_issue_ldr) begin
        sd_req     <= ~sd_req;
        sd_a       <= r_ldr_a;
        sd_we      <= 1'b1;
        sd_ds      <= r_ldr_a[0] ? 2'b10 : 2'b01;
        sd_d       <= {r_ldr_d, r_ldr_d};
        r_wait_cnt <= 8'h00;
      end
      if ((r_state == ST_WAIT_CPU) || (r_state == ST_WAIT_LDR)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
        if (w_done && (r_state == ST_WAIT_CPU) && !sd_we) begin
          cpu_q <= sd_a[0] ? sd_q[15:8] : sd_q[7:0];
        end
        if (w_tmo) timeout_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed self-checking bench for ram_port_arbiter with a small
//            SDRAM toggle-acknowledge model (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_oe, cpu_we;
  logic [15:0] cpu_ad;
  logic [7:0]  cpu_d;
  logic [7:0]  cpu_q;
  logic        cpu_busy;
  logic        ldr_wr;
  logic [15:0] ldr_ad;
  logic [7:0]  ldr_d;
  logic        ldr_busy, ldr_ovf, timeout_err;
  logic        sd_req;
  logic        sd_ack = 1'b0;
  logic [15:0] sd_a;
  logic        sd_we;
  logic [1:0]  sd_ds;
  logic [15:0] sd_d;
  logic [15:0] sd_q;

  int total = 0;
  int bad   = 0;
  logic ack_en = 1'b1;
  int   ack_cnt = 0;
  logic req_save;

  ram_port_arbiter #(.TIMEOUT(4)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
    .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_q(cpu_q), .cpu_busy(cpu_busy),
    .ldr_wr(ldr_wr), .ldr_ad(ldr_ad), .ldr_d(ldr_d),
    .ldr_busy(ldr_busy), .ldr_ovf(ldr_ovf), .timeout_err(timeout_err),
    .sd_req(sd_req), .sd_ack(sd_ack), .sd_a(sd_a), .sd_we(sd_we),
    .sd_ds(sd_ds), .sd_d(sd_d), .sd_q(sd_q)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: acknowledge toggles three cycles after a request toggle.
  always @(posedge clk_sys) begin
    if (ack_en && (sd_req !== sd_ack)) begin
      if (ack_cnt == 2) begin
        sd_ack  <= sd_req;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cpu(input string tag);
    int n = 0;
    while (cpu_busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, cpu_busy}, 32'd0);
  endtask

  task automatic wait_ldr(input string tag);
    int n = 0;
    while (ldr_busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, ldr_busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_cs = 0; cpu_oe = 0; cpu_we = 0; cpu_ad = 16'h0; cpu_d = 8'h0;
    ldr_wr = 0; ldr_ad = 16'h0; ldr_d = 8'h0; sd_q = 16'h0;
    tick(); tick();
    chk("rst_req",   {31'd0, sd_req}, 32'd0);
    chk("rst_ds",    {30'd0, sd_ds}, 32'd3);
    chk("rst_a",     {16'd0, sd_a}, 32'd0);
    chk("rst_q",     {24'd0, cpu_q}, 32'd0);
    chk("rst_busy",  {30'd0, cpu_busy, ldr_busy}, 32'd0);
    chk("rst_flags", {30'd0, ldr_ovf, timeout_err}, 32'd0);
    reset = 1'b0;
    tick();

    // CPU read at odd address, high byte returned.
    cpu_cs = 1; cpu_oe = 1; cpu_ad = 16'h1235; sd_q = 16'hAB12;
    tick();
    chk("rd_pend", {31'd0, cpu_busy}, 32'd1);
    tick();
    chk("rd_req", {31'd0, sd_req}, 32'd1);
    chk("rd_a",   {16'd0, sd_a}, 32'h1235);
    chk("rd_ds",  {30'd0, sd_ds}, 32'd3);
    chk("rd_we",  {31'd0, sd_we}, 32'd0);
    tick(); tick(); tick();
    chk("rd_q_early", {24'd0, cpu_q}, 32'd0);
    chk("rd_busy_mid", {31'd0, cpu_busy}, 32'd1);
    tick();
    chk("rd_q",    {24'd0, cpu_q}, 32'hAB);
    chk("rd_done", {31'd0, cpu_busy}, 32'd0);

    // CPU write at even address, low lane.
    cpu_oe = 0; cpu_we = 1; cpu_ad = 16'h0400; cpu_d = 8'h5A;
    tick(); tick();
    chk("wr_req", {31'd0, sd_req}, 32'd0);
    chk("wr_we",  {31'd0, sd_we}, 32'd1);
    chk("wr_ds",  {30'd0, sd_ds}, 32'd1);
    chk("wr_d",   {16'd0, sd_d}, 32'h5A5A);
    chk("wr_a",   {16'd0, sd_a}, 32'h0400);
    wait_cpu("wr_complete");
    tick(); tick();
    chk("wr_one_toggle", {31'd0, sd_req}, 32'd0);
    cpu_cs = 0; cpu_we = 0;
    tick();

    // Contention: loader write and CPU read on the same edge.
    ldr_wr = 1; ldr_ad = 16'h8000; ldr_d = 8'h11;
    cpu_cs = 1; cpu_oe = 1; cpu_ad = 16'h2001; sd_q = 16'h3344;
    tick();
    ldr_wr = 0;
    chk("ct_busy", {30'd0, cpu_busy, ldr_busy}, 32'd3);
    tick();
    chk("ct_cpu_first", {16'd0, sd_a}, 32'h2001);
    chk("ct_cpu_we", {31'd0, sd_we}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("ct_cpu_q", {24'd0, cpu_q}, 32'h33);
    chk("ct_ldr_wait", {16'd0, sd_a}, 32'h2001);
    tick();
    chk("ct_ldr_a",  {16'd0, sd_a}, 32'h8000);
    chk("ct_ldr_ds", {30'd0, sd_ds}, 32'd1);
    chk("ct_ldr_d",  {16'd0, sd_d}, 32'h1111);
    chk("ct_ldr_we", {31'd0, sd_we}, 32'd1);
    wait_ldr("ct_ldr_complete");
    chk("ct_ovf", {31'd0, ldr_ovf}, 32'd0);
    cpu_cs = 0; cpu_oe = 0;
    tick();

    // Overflow: second loader write while the first is buffered.
    ldr_wr = 1; ldr_ad = 16'h9001; ldr_d = 8'h22;
    tick();
    ldr_ad = 16'hA000; ldr_d = 8'h33;
    tick();
    ldr_wr = 0;
    chk("ov_a",   {16'd0, sd_a}, 32'h9001);
    chk("ov_ds",  {30'd0, sd_ds}, 32'd2);
    chk("ov_d",   {16'd0, sd_d}, 32'h2222);
    chk("ov_flag", {31'd0, ldr_ovf}, 32'd1);
    wait_ldr("ov_complete");
    req_save = sd_req;
    tick(); tick(); tick();
    chk("ov_no_second", {16'd0, sd_a}, 32'h9001);
    chk("ov_no_toggle", {31'd0, sd_req}, {31'd0, req_save});

    // Timeout with a CPU access coalesced during the wait.
    ack_en = 0;
    cpu_cs = 1; cpu_oe = 1; cpu_ad = 16'h0010; sd_q = 16'hC3A5;
    tick(); tick();
    chk("to_issue", {16'd0, sd_a}, 32'h0010);
    cpu_ad = 16'h0011;
    tick(); tick(); tick();
    chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_q_kept", {24'd0, cpu_q}, 32'h33);
    chk("to_pend", {31'd0, cpu_busy}, 32'd1);
    tick();
    chk("to_sync", {31'd0, sd_req ^ sd_ack}, 32'd0);
    ack_en = 1;
    tick();
    chk("to_reissue_a", {16'd0, sd_a}, 32'h0011);
    chk("to_reissue_req", {31'd0, sd_req ^ sd_ack}, 32'd1);
    wait_cpu("to_reissue_complete");
    chk("to_reissue_q", {24'd0, cpu_q}, 32'hC3);
    cpu_cs = 0; cpu_oe = 0;
    tick();

    // Bring sd_ack to 1 with completed writes, then reset mid WAIT_CPU.
    for (int i = 0; i < 3 && sd_ack !== 1'b1; i++) begin
      cpu_cs = 1; cpu_we = 1; cpu_ad = 16'h0100; cpu_d = 8'h77;
      tick(); tick();
      wait_cpu("rs_prep");
      cpu_cs = 0; cpu_we = 0;
      tick();
    end
    chk("rs_ack_one", {31'd0, sd_ack}, 32'd1);
    ack_en = 0;
    cpu_cs = 1; cpu_oe = 1; cpu_ad = 16'h0201; sd_q = 16'h5566;
    tick(); tick(); tick();
    chk("rs_in_wait", {31'd0, sd_req}, 32'd0);
    reset = 1'b1;
    cpu_cs = 0; cpu_oe = 0;
    #1;
    chk("rs_req",   {31'd0, sd_req}, 32'd0);
    chk("rs_a",     {16'd0, sd_a}, 32'd0);
    chk("rs_ds_we", {29'd0, sd_ds, sd_we}, 32'd6);
    chk("rs_d",     {16'd0, sd_d}, 32'd0);
    chk("rs_q",     {24'd0, cpu_q}, 32'd0);
    chk("rs_flags", {28'd0, cpu_busy, ldr_busy, ldr_ovf, timeout_err}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rs_sync_req", {31'd0, sd_req}, 32'd1);
    tick(); tick();
    chk("rs_no_q", {24'd0, cpu_q}, 32'd0);
    chk("rs_idle", {31'd0, cpu_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of clk_sys cycles to wait for an SDRAM acknowledge; legal range 1..255.
REQ-002 SHALL have port clk_sys, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-004 SHALL have port cpu_cs / cpu_oe / cpu_we, input, 1 each, the Oric RAM bus strobes.
REQ-005 SHALL have port cpu_ad, input, 16, the CPU byte address.
REQ-006 SHALL have port cpu_d, input, 8, the CPU write data.
REQ-007 SHALL have port cpu_q, output, 8, the CPU read data, held between reads.
REQ-008 SHALL have port cpu_busy, output, 1: CPU access pending or in flight.
REQ-009 SHALL have port ldr_wr, input, 1, a one-cycle loader write strobe.
REQ-010 SHALL have port ldr_ad, input, 16, the loader write address.
REQ-011 SHALL have port ldr_d, input, 8, the loader write data.
REQ-012 SHALL have port ldr_busy, output, 1: loader entry buffered or in flight.
REQ-013 SHALL have port ldr_ovf, output, 1, sticky: a loader write was dropped.
REQ-014 SHALL have port timeout_err, output, 1, sticky: an SDRAM acknowledge timed out.
REQ-015 SHALL have port sd_req, output, 1, the toggle request to the SDRAM port.
REQ-016 SHALL have port sd_ack, input, 1, the toggle acknowledge; it equals sd_req when the port is idle.
REQ-017 SHALL have port sd_a, output, 16, the SDRAM address.
REQ-018 SHALL have port sd_we, output, 1, the SDRAM write enable.
REQ-019 SHALL have port sd_ds, output, 2, the SDRAM byte-lane enables.
REQ-020 SHALL have port sd_d, output, 16, the SDRAM write data.
REQ-021 SHALL have port sd_q, input, 16, the SDRAM read data.

Function
REQ-022 SHALL register cs&oe, cs&we and cpu_ad each cycle and raise a CPU event on any of these: rising cs&oe; rising cs&we; or cs&oe high with cpu_ad differing from its registered value.
REQ-023 SHALL, on a CPU event, set cpu_pend and capture the address, we and data; a later event before issue overwrites the capture (coalesce, newest wins).
REQ-024 SHALL, on ldr_wr with the loader buffer empty, capture ldr_ad and ldr_d and set ldr_pend.
REQ-025 SHALL, on ldr_wr while ldr_busy=1, drop the write and set ldr_ovf.
REQ-026 SHALL implement states SYNC, IDLE, WAIT_CPU and WAIT_LDR.
REQ-027 SHALL, in SYNC, set sd_req to sd_ack and go to IDLE on the next edge.
REQ-028 SHALL, in IDLE with cpu_pend set, load sd_a/sd_we/sd_ds/sd_d, toggle sd_req, clear cpu_pend and enter WAIT_CPU on that edge.
REQ-029 SHALL otherwise, in IDLE with ldr_pend set, do the same with the loader capture, sd_we=1, and enter WAIT_LDR.
REQ-030 SHALL give CPU strict priority; an issued transfer is never preempted.
REQ-031 SHALL drive sd_ds = 2'b11 for reads, 2'b10 for writes with sd_a[0]=1, and 2'b01 for writes with sd_a[0]=0.
REQ-032 SHALL drive sd_d = {byte, byte}.
REQ-033 SHALL, in WAIT_*, complete at the edge where sd_ack equals sd_req.
REQ-034 SHALL, on completion of a CPU read, load cpu_q = sd_a[0] ? sd_q[15:8] : sd_q[7:0] at the completion edge.
REQ-035 SHALL go to IDLE on completion and clear ldr_busy when WAIT_LDR completes.
REQ-036 SHALL keep an 8-bit wait counter: cleared on issue, incremented each WAIT_* cycle; on reaching TIMEOUT it sets timeout_err, leaves cpu_q unchanged, and enters SYNC.
REQ-037 SHALL keep capturing CPU events arriving during WAIT_CPU into cpu_pend; they are issued after return to IDLE.
REQ-038 SHALL make the capture win when a CPU event and the cpu_pend-clear from an issue occur on the same edge (cpu_pend stays 1).
REQ-039 SHALL drive cpu_busy = cpu_pend | (state==WAIT_CPU) and ldr_busy = ldr_pend | (state==WAIT_LDR).
REQ-040 SHALL issue the next transfer no earlier than one edge after completion.

Reset
REQ-041 SHALL, on reset assertion, immediately force: state SYNC; sd_req=0; sd_a=0, sd_we=0, sd_ds=2'b11, sd_d=0; cpu_q=0; cpu_pend=0, ldr_pend=0; ldr_ovf=0, timeout_err=0; the wait counter and edge registers to 0.
REQ-042 SHALL abandon any transfer in flight when reset is asserted mid-transfer; after release the first edge is spent in SYNC, so no stale acknowledge is accepted.

Verification
REQ-043 CPU read: cs=oe=1, ad=0x1235; ack toggles 3 cycles after req; sd_q=0xAB12 -> sd_ds=11, cpu_q=0xAB at completion, cpu_busy low the next cycle.
REQ-044 CPU write: ad=0x0400, d=0x5A -> sd_we=1, sd_ds=01, sd_d=0x5A5A, exactly one sd_req toggle.
REQ-045 Contention: ldr_wr(0x8000, 0x11) on the same edge as a CPU read event -> CPU issued first, loader on the edge after CPU completion; ldr_ovf stays 0.
REQ-046 Overflow: two ldr_wr one cycle apart, ack held off -> second dropped, ldr_ovf=1, only the first reaches SDRAM.
REQ-047 Timeout: ack never toggles, TIMEOUT=4 -> timeout_err=1 after 4 WAIT cycles, SYNC sets sd_req=sd_ack, a pending CPU access issues afterwards.
REQ-048 Reset mid-WAIT_CPU with sd_ack=1 -> outputs at reset values, sd_req=1 after SYNC, no cpu_q update.
